// File: rtl/swerv_types.sv
// Shared types for the LSU DCCM arbiter: FSM states and word geometry.
package swerv_types;

    typedef enum logic [1:0] {
        IDLE,
        MRG,
        WR
    } dccm_arb_state_e;

    localparam int unsigned DccmWordBytes = 4;

endpackage

// File: rtl/lsu_dccm_arb_if.sv
// Request/response bundle between core, DMA, DCCM and the LSU DCCM arbiter.
interface lsu_dccm_arb_if #(
    parameter int DCCM_BITS = 16
);
    logic                 core_req_valid;
    logic                 core_req_ready;
    logic                 core_req_wr;
    logic [DCCM_BITS-1:0] core_req_addr;
    logic [31:0]          core_req_wdata;

    logic                 dma_req_valid;
    logic                 dma_req_ready;
    logic                 dma_req_wr;
    logic [DCCM_BITS-1:0] dma_req_addr;
    logic [31:0]          dma_req_wdata;
    logic [3:0]           dma_req_be;

    logic                 dccm_wren;
    logic                 dccm_rden;
    logic [DCCM_BITS-1:0] dccm_wr_addr;
    logic [DCCM_BITS-1:0] dccm_rd_addr_lo;
    logic [DCCM_BITS-1:0] dccm_rd_addr_hi;
    logic [31:0]          dccm_wr_data;
    logic [31:0]          dccm_rd_data_lo;

    logic                 core_rsp_valid;
    logic                 dma_rsp_valid;
    logic [31:0]          rsp_data;

    // Arbiter view.
    modport slave (
        input  core_req_valid, core_req_wr, core_req_addr, core_req_wdata,
        input  dma_req_valid, dma_req_wr, dma_req_addr, dma_req_wdata, dma_req_be,
        input  dccm_rd_data_lo,
        output core_req_ready, dma_req_ready,
        output dccm_wren, dccm_rden, dccm_wr_addr, dccm_rd_addr_lo, dccm_rd_addr_hi,
        output dccm_wr_data,
        output core_rsp_valid, dma_rsp_valid, rsp_data
    );

    // Requester and memory view.
    modport master (
        output core_req_valid, core_req_wr, core_req_addr, core_req_wdata,
        output dma_req_valid, dma_req_wr, dma_req_addr, dma_req_wdata, dma_req_be,
        output dccm_rd_data_lo,
        input  core_req_ready, dma_req_ready,
        input  dccm_wren, dccm_rden, dccm_wr_addr, dccm_rd_addr_lo, dccm_rd_addr_hi,
        input  dccm_wr_data,
        input  core_rsp_valid, dma_rsp_valid, rsp_data
    );
endinterface

// File: rtl/lsu_dccm_merge.sv
// Byte-lane merge for DMA partial writes: enabled lanes from wdata, others from rd_data.
module lsu_dccm_merge
    import swerv_types::*;
(
    input  logic [3:0]  be,
    input  logic [31:0] wdata,
    input  logic [31:0] rd_data,
    output logic [31:0] merged
);

    always_comb begin
        merged = rd_data;
        for (int i = 0; i < int'(DccmWordBytes); i++) begin
            if (be[i]) merged[8*i +: 8] = wdata[8*i +: 8];
        end
    end

endmodule

// File: rtl/lsu_dccm_arb.sv
// Arbitrates core and DMA access to the DCCM; DMA partial writes run as read-merge-write.
module lsu_dccm_arb
    import swerv_types::*;
#(
    parameter int DCCM_BITS      = 16,
    parameter int DMA_STARVE_MAX = 4
) (
    input logic           clk,
    input logic           rst,
    input logic           lsu_freeze_dc3,
    lsu_dccm_arb_if.slave bus
);

    localparam logic [3:0]           StarveMax = 4'(DMA_STARVE_MAX);
    localparam logic [DCCM_BITS-1:0] AlignMask = ~DCCM_BITS'(3);

    dccm_arb_state_e      state_q, state_d;
    logic [3:0]           starve_q, starve_d;
    logic                 core_pend_q, core_pend_d;
    logic                 dma_pend_q, dma_pend_d;
    logic [31:0]          merge_q, merge_d;
    logic [31:0]          merged;
    logic                 dma_win;
    logic                 dma_partial;
    logic [DCCM_BITS-1:0] core_addr;
    logic [DCCM_BITS-1:0] dma_addr;

    assign core_addr   = bus.core_req_addr & AlignMask;
    assign dma_addr    = bus.dma_req_addr & AlignMask;
    assign dma_partial = (bus.dma_req_be != 4'h0) && (bus.dma_req_be != 4'hF);

    lsu_dccm_merge u_merge (
        .be      (bus.dma_req_be),
        .wdata   (bus.dma_req_wdata),
        .rd_data (bus.dccm_rd_data_lo),
        .merged  (merged)
    );

    always_comb begin
        state_d             = state_q;
        starve_d            = starve_q;
        core_pend_d         = core_pend_q;
        dma_pend_d          = dma_pend_q;
        merge_d             = merge_q;
        dma_win             = 1'b0;
        bus.core_req_ready  = 1'b0;
        bus.dma_req_ready   = 1'b0;
        bus.dccm_wren       = 1'b0;
        bus.dccm_rden       = 1'b0;
        bus.dccm_wr_addr    = '0;
        bus.dccm_rd_addr_lo = '0;
        bus.dccm_wr_data    = '0;
        bus.core_rsp_valid  = 1'b0;
        bus.dma_rsp_valid   = 1'b0;
        bus.rsp_data        = rst ? 32'h0 : bus.dccm_rd_data_lo;

        // Reset and freeze both silence the port; everything below only runs when live.
        if (!rst && !lsu_freeze_dc3) begin
            bus.core_rsp_valid = core_pend_q;
            bus.dma_rsp_valid  = dma_pend_q;
            core_pend_d        = 1'b0;
            dma_pend_d         = 1'b0;

            unique case (state_q)
                IDLE: begin
                    dma_win = bus.dma_req_valid &&
                              (!bus.core_req_valid || starve_q == StarveMax);
                    if (dma_win) begin
                        if (!bus.dma_req_wr) begin
                            bus.dma_req_ready   = 1'b1;
                            bus.dccm_rden       = 1'b1;
                            bus.dccm_rd_addr_lo = dma_addr;
                            dma_pend_d          = 1'b1;
                        end else if (dma_partial) begin
                            // Internal read for the merge; no response to the DMA.
                            bus.dccm_rden       = 1'b1;
                            bus.dccm_rd_addr_lo = dma_addr;
                            state_d             = MRG;
                        end else begin
                            bus.dma_req_ready = 1'b1;
                            if (bus.dma_req_be == 4'hF) begin
                                bus.dccm_wren    = 1'b1;
                                bus.dccm_wr_addr = dma_addr;
                                bus.dccm_wr_data = bus.dma_req_wdata;
                            end
                        end
                    end else if (bus.core_req_valid) begin
                        bus.core_req_ready = 1'b1;
                        if (bus.core_req_wr) begin
                            bus.dccm_wren    = 1'b1;
                            bus.dccm_wr_addr = core_addr;
                            bus.dccm_wr_data = bus.core_req_wdata;
                        end else begin
                            bus.dccm_rden       = 1'b1;
                            bus.dccm_rd_addr_lo = core_addr;
                            core_pend_d         = 1'b1;
                        end
                    end
                end
                MRG: begin
                    merge_d = merged;
                    state_d = WR;
                end
                WR: begin
                    bus.dccm_wren     = 1'b1;
                    bus.dccm_wr_addr  = dma_addr;
                    bus.dccm_wr_data  = merge_q;
                    bus.dma_req_ready = 1'b1;
                    state_d           = IDLE;
                end
                default: state_d = IDLE;
            endcase

            // An RMW in flight counts as DMA being served, so it never ages the counter.
            if (dma_win || state_q != IDLE) begin
                starve_d = 4'h0;
            end else if (bus.dma_req_valid && starve_q < StarveMax) begin
                starve_d = starve_q + 4'h1;
            end
        end

        bus.dccm_rd_addr_hi = bus.dccm_rd_addr_lo;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            starve_q    <= 4'h0;
            core_pend_q <= 1'b0;
            dma_pend_q  <= 1'b0;
            merge_q     <= 32'h0;
        end else begin
            state_q     <= state_d;
            starve_q    <= starve_d;
            core_pend_q <= core_pend_d;
            dma_pend_q  <= dma_pend_d;
            merge_q     <= merge_d;
        end
    end

endmodule

// File: tb/tb_lsu_dccm_arb.sv
// Randomised and directed bench for lsu_dccm_arb against a transaction-level model.
module tb_lsu_dccm_arb;

    localparam int AW   = 16;
    localparam int SMAX = 4;

    logic clk = 1'b0;
    logic rst;
    logic frz;

    always #5 clk = ~clk;

    lsu_dccm_arb_if #(.DCCM_BITS(AW)) bus ();

    lsu_dccm_arb #(
        .DCCM_BITS      (AW),
        .DMA_STARVE_MAX (SMAX)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .lsu_freeze_dc3 (frz),
        .bus            (bus)
    );

    int checks   = 0;
    int failures = 0;

    logic [31:0] mem  [16];  // memory as the DUT actually wrote it
    logic [31:0] gold [16];  // memory as the model says it must be

    // Model state.
    int          phase;      // 0 free, 1 merging, 2 writing back
    int          starve;
    bit          m_cpend, m_dpend;
    logic [31:0] m_cval, m_dval;

    // Snapshot of DUT outputs in the last stepped cycle.
    logic        s_cready, s_dready, s_rden, s_wren, s_crsp, s_drsp;
    logic [15:0] s_rd_lo, s_rd_hi, s_wr_addr;
    logic [31:0] s_wr_data, s_rsp_data;

    bit c_acc, d_acc;
    int n_core, n_dma;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic int widx(input logic [15:0] a);
        return int'(a[5:2]);
    endfunction

    function automatic logic [31:0] merge_bytes(input logic [31:0] old_w,
                                                input logic [31:0] new_w,
                                                input logic [3:0] be);
        logic [31:0] r;
        r = old_w;
        for (int b = 0; b < 4; b++) if (be[b]) r[8*b +: 8] = new_w[8*b +: 8];
        return r;
    endfunction

    // One clock cycle: entered just after a negedge with inputs already driven.
    task automatic step();
        bit          e_cready, e_dready, e_rden, e_wren, e_crsp, e_drsp, dwin;
        logic [15:0] e_rd_addr, e_wr_addr, ca, da;
        logic [31:0] e_wr_data, e_rsp;
        #1;
        s_cready = bus.core_req_ready;   s_dready  = bus.dma_req_ready;
        s_rden   = bus.dccm_rden;        s_wren    = bus.dccm_wren;
        s_crsp   = bus.core_rsp_valid;   s_drsp    = bus.dma_rsp_valid;
        s_rd_lo  = bus.dccm_rd_addr_lo;  s_rd_hi   = bus.dccm_rd_addr_hi;
        s_wr_addr = bus.dccm_wr_addr;    s_wr_data = bus.dccm_wr_data;
        s_rsp_data = bus.rsp_data;

        {e_cready, e_dready, e_rden, e_wren, e_crsp, e_drsp} = '0;
        e_rd_addr = '0; e_wr_addr = '0; e_wr_data = '0; e_rsp = '0;
        ca = {bus.core_req_addr[15:2], 2'b00};
        da = {bus.dma_req_addr[15:2], 2'b00};

        if (rst) begin
            phase = 0; starve = 0; m_cpend = 0; m_dpend = 0;
        end else if (!frz) begin
            e_crsp = m_cpend; e_drsp = m_dpend;
            e_rsp  = m_cpend ? m_cval : m_dval;
            m_cpend = 0; m_dpend = 0;
            if (phase == 0) begin
                dwin = bus.dma_req_valid && (!bus.core_req_valid || starve == SMAX);
                if (dwin) begin
                    starve = 0;
                    if (!bus.dma_req_wr) begin
                        e_dready = 1; e_rden = 1; e_rd_addr = da;
                        m_dpend = 1; m_dval = gold[widx(da)];
                    end else if (bus.dma_req_be == 4'hF) begin
                        e_dready = 1; e_wren = 1; e_wr_addr = da;
                        e_wr_data = bus.dma_req_wdata; gold[widx(da)] = e_wr_data;
                    end else if (bus.dma_req_be == 4'h0) begin
                        e_dready = 1;
                    end else begin
                        e_rden = 1; e_rd_addr = da; phase = 1;
                    end
                end else if (bus.core_req_valid) begin
                    e_cready = 1;
                    if (bus.dma_req_valid && starve < SMAX) starve++;
                    if (bus.core_req_wr) begin
                        e_wren = 1; e_wr_addr = ca; e_wr_data = bus.core_req_wdata;
                        gold[widx(ca)] = e_wr_data;
                    end else begin
                        e_rden = 1; e_rd_addr = ca; m_cpend = 1; m_cval = gold[widx(ca)];
                    end
                end
            end else if (phase == 1) begin
                phase = 2;
            end else begin
                e_wren = 1; e_dready = 1; e_wr_addr = da;
                e_wr_data = merge_bytes(gold[widx(da)], bus.dma_req_wdata, bus.dma_req_be);
                gold[widx(da)] = e_wr_data;
                phase = 0;
            end
        end

        chk("core_req_ready", s_cready, e_cready);
        chk("dma_req_ready", s_dready, e_dready);
        chk("dccm_rden", s_rden, e_rden);
        chk("dccm_wren", s_wren, e_wren);
        chk("core_rsp_valid", s_crsp, e_crsp);
        chk("dma_rsp_valid", s_drsp, e_drsp);
        if (e_rden) begin
            chk("rd_addr_lo", s_rd_lo, e_rd_addr);
            chk("rd_addr_hi", s_rd_hi, e_rd_addr);
        end
        if (e_wren) begin
            chk("wr_addr", s_wr_addr, e_wr_addr);
            chk("wr_data", s_wr_data, e_wr_data);
        end
        if (e_crsp || e_drsp) chk("rsp_data", s_rsp_data, e_rsp);
        if (rst) begin
            chk("rst_wr_addr", s_wr_addr, 0);
            chk("rst_rd_addr", s_rd_lo, 0);
            chk("rst_wr_data", s_wr_data, 0);
            chk("rst_rsp_data", s_rsp_data, 0);
        end
        c_acc = e_cready; d_acc = e_dready;
        if (e_cready) n_core++;
        if (e_dready) n_dma++;

        @(posedge clk);
        #1;
        if (s_wren) mem[widx(s_wr_addr)] = s_wr_data;
        if (s_rden) bus.dccm_rd_data_lo = mem[widx(s_rd_lo)];
        @(negedge clk);
    endtask

    task automatic set_core(input bit v, input bit wr, input logic [15:0] a, input logic [31:0] d);
        bus.core_req_valid = v; bus.core_req_wr = wr; bus.core_req_addr = a; bus.core_req_wdata = d;
    endtask

    task automatic set_dma(input bit v, input bit wr, input logic [15:0] a, input logic [31:0] d,
                           input logic [3:0] be);
        bus.dma_req_valid = v; bus.dma_req_wr = wr; bus.dma_req_addr = a;
        bus.dma_req_wdata = d; bus.dma_req_be = be;
    endtask

    task automatic poke(input int i, input logic [31:0] w);
        mem[i] = w; gold[i] = w;
    endtask

    initial begin
        int grant_at;
        logic [3:0] be_pick;
        rst = 1'b1; frz = 1'b0;
        phase = 0; starve = 0; m_cpend = 0; m_dpend = 0; m_cval = '0; m_dval = '0;
        n_core = 0; n_dma = 0;
        bus.dccm_rd_data_lo = '0;
        set_core(0, 0, '0, '0);
        set_dma(0, 0, '0, '0, '0);
        for (int i = 0; i < 16; i++) poke(i, $urandom);

        // Reset state, including reset winning over freeze with requests pending.
        @(negedge clk);
        step();
        frz = 1'b1;
        set_core(1, 0, 16'h0004, '0);
        step();
        chk("rst_core_ready", s_cready, 0);
        rst = 1'b0; frz = 1'b0;
        set_core(0, 0, '0, '0);

        // Core read of 0x0010 and its response one cycle later.
        poke(4, 32'hCAFEF00D);
        set_core(1, 0, 16'h0010, '0);
        step();
        chk("d42_rden", s_rden, 1);
        chk("d42_lo", s_rd_lo, 16'h0010);
        chk("d42_hi", s_rd_hi, 16'h0010);
        set_core(0, 0, '0, '0);
        step();
        chk("d42_rsp_valid", s_crsp, 1);
        chk("d42_rsp_data", s_rsp_data, 32'hCAFEF00D);

        // DMA partial write: ready two cycles after grant, merged word stored.
        poke(8, 32'h11223344);
        set_dma(1, 1, 16'h0020, 32'hAABBCCDD, 4'b0101);
        step();
        chk("d43_grant_rden", s_rden, 1);
        chk("d43_grant_ready", s_dready, 0);
        step();
        chk("d43_mrg_ready", s_dready, 0);
        step();
        chk("d43_wr_ready", s_dready, 1);
        chk("d43_wr_data", s_wr_data, 32'h11BB33DD);
        set_dma(0, 0, '0, '0, '0);
        step();
        chk("d43_mem", mem[8], 32'h11BB33DD);

        // Starvation: DMA wins on the 5th cycle, and again 5 cycles later.
        set_core(1, 0, 16'h0004, '0);
        set_dma(1, 0, 16'h0008, '0, '0);
        grant_at = 0;
        for (int i = 1; i <= 5; i++) begin
            step();
            if (s_dready && grant_at == 0) grant_at = i;
        end
        chk("d44_first_grant", grant_at, 5);
        set_dma(1, 0, 16'h000C, '0, '0);
        grant_at = 0;
        for (int i = 1; i <= 8 && grant_at == 0; i++) begin
            step();
            if (s_dready) grant_at = i;
        end
        chk("d44_regrant", grant_at, 5);
        set_core(0, 0, '0, '0);
        set_dma(0, 0, '0, '0, '0);
        step();

        // Freeze for 3 cycles while merging.
        set_dma(1, 1, 16'h0020, 32'h55667788, 4'b1010);
        step();
        chk("d45_grant_rden", s_rden, 1);
        frz = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step();
            chk("d45_frz_ops", {s_rden, s_wren, s_dready}, 0);
        end
        frz = 1'b0;
        step();
        chk("d45_release_wren", s_wren, 0);
        step();
        chk("d45_wren", s_wren, 1);
        chk("d45_wr_data", s_wr_data, 32'h55BB77DD);
        set_dma(0, 0, '0, '0, '0);
        step();

        // Reset during write-back abandons it; the held request replays.
        poke(12, 32'h12345678);
        set_dma(1, 1, 16'h0030, 32'h0000BEEF, 4'b0011);
        step();
        step();
        rst = 1'b1;
        step();
        chk("d46_rst_wren", s_wren, 0);
        chk("d46_rst_ready", s_dready, 0);
        rst = 1'b0;
        step();
        chk("d46_regrant_rden", s_rden, 1);
        chk("d46_mem_untouched", mem[12], 32'h12345678);
        step();
        step();
        chk("d46_wren", s_wren, 1);
        chk("d46_wr_data", s_wr_data, 32'h1234BEEF);
        set_dma(0, 0, '0, '0, '0);
        step();
        chk("d46_mem", mem[12], 32'h1234BEEF);

        // Random traffic with freeze and occasional reset.
        n_core = 0; n_dma = 0;
        c_acc = 1; d_acc = 1;
        for (int cyc = 0; cyc < 3000; cyc++) begin
            if (c_acc || !bus.core_req_valid)
                set_core(($urandom % 3) != 0, $urandom % 2, 16'($urandom_range(0, 63)), $urandom);
            if (d_acc || !bus.dma_req_valid) begin
                case ($urandom % 4)
                    0: be_pick = 4'h0;
                    1: be_pick = 4'hF;
                    default: be_pick = 4'($urandom);
                endcase
                set_dma(($urandom % 3) == 0, $urandom % 2, 16'($urandom_range(0, 63)), $urandom,
                        be_pick);
            end
            frz = ($urandom % 8) == 0;
            rst = ($urandom % 97) == 0;
            step();
        end
        chk("rand_core_progress", n_core > 100, 1);
        chk("rand_dma_progress", n_dma > 50, 1);
        rst = 1'b0; frz = 1'b0;
        set_core(0, 0, '0, '0);
        set_dma(0, 0, '0, '0, '0);
        step();
        step();
        for (int i = 0; i < 16; i++) chk("final_mem", mem[i], gold[i]);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
